// File: rtl/sa_pkg.sv
// Shared constants and state encoding for the systolic-array tile scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sa_pkg;

  localparam int N         = 5;                // array dimension (rows = cols)
  localparam int AW        = 8;                // weight/result memory address width
  localparam int DRAIN_LEN = N;                // cycles for last partial sums to exit
  localparam int FEED_LEN  = 2 * N - 1;        // skewed feed length
  localparam int RES_LEN   = N * N;            // results written per pass
  localparam int CW        = $clog2(RES_LEN);  // shared counter width (covers N*N-1)

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOADW = 3'd1,
    FEED  = 3'd2,
    DRAIN = 3'd3,
    WRITE = 3'd4,
    DONE  = 3'd5
  } state_t;

endpackage

// File: rtl/sa_skew_gen.sv
// Per-row skewed input enables: row r is active while r <= k < r+N.
// Latency: combinational; the caller registers the result.
// Backpressure: none, pure decode of the feed index.
module sa_skew_gen
  import sa_pkg::*;
(
  input  logic          feed,
  input  logic [CW-1:0] k,
  output logic [N-1:0]  en
);

  // Row r sees element k-r only inside its N-cycle window.
  always_comb begin
    en = '0;
    for (int r = 0; r < N; r++) begin
      en[r] = feed && (k >= CW'(r)) && (k < CW'(r + N));
    end
  end

endmodule

// File: rtl/sa_tile_scheduler.sv
// One-pass sequencer for the NxN weight-stationary tile: load, feed, drain, write-back.
// Latency: start edge at t0 -> LOADW t0+1..t0+5, FEED ..t0+14, DRAIN ..t0+19, WRITE ..t0+44, com t0+45.
// Backpressure: none; the pass runs at fixed rate, init must drop in DONE before the next pass.
module sa_tile_scheduler
  import sa_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          init,
  input  logic [AW-1:0] base_address,
  output logic          com,
  output logic          busy,
  output logic [AW-1:0] wmem_addr,
  output logic          sa_wload,
  output logic [N-1:0]  in_en,
  output logic [CW-1:0] feed_cnt,
  output logic          res_we,
  output logic [AW-1:0] res_addr,
  output logic [CW-1:0] res_sel
);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] base_q, base_d;
  logic          init_q;
  logic          feed_d;
  logic [N-1:0]  in_en_d;

  // Next state, shared counter and base latch. The counter restarts at 0 on
  // every state change so each phase indexes from 0.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    base_d  = base_q;
    case (state_q)
      IDLE: begin
        if (init && !init_q) begin
          state_d = LOADW;
          base_d  = base_address;
          cnt_d   = '0;
        end
      end
      LOADW: begin
        if (cnt_q == CW'(N - 1)) begin
          state_d = FEED;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      FEED: begin
        if (cnt_q == CW'(FEED_LEN - 1)) begin
          state_d = DRAIN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DRAIN: begin
        if (cnt_q == CW'(DRAIN_LEN - 1)) begin
          state_d = WRITE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      WRITE: begin
        if (cnt_q == CW'(RES_LEN - 1)) begin
          state_d = DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        cnt_d = '0;
        if (!init) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign feed_d = (state_d == FEED);

  sa_skew_gen u_skew (
    .feed (feed_d),
    .k    (cnt_d),
    .en   (in_en_d)
  );

  // State, counter, base latch and start-edge history.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      base_q  <= '0;
      init_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      base_q  <= base_d;
      init_q  <= init;
    end
  end

  // Outputs decoded from the next state so they align with the state register
  // and never glitch between phases.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      com       <= 1'b0;
      busy      <= 1'b0;
      wmem_addr <= '0;
      sa_wload  <= 1'b0;
      in_en     <= '0;
      feed_cnt  <= '0;
      res_we    <= 1'b0;
      res_addr  <= '0;
      res_sel   <= '0;
    end else begin
      com       <= (state_d == DONE);
      busy      <= (state_d == LOADW) || (state_d == FEED) ||
                   (state_d == DRAIN) || (state_d == WRITE);
      sa_wload  <= (state_d == LOADW);
      wmem_addr <= (state_d == LOADW) ? AW'(cnt_d) : '0;
      in_en     <= in_en_d;
      feed_cnt  <= feed_d ? cnt_d : '0;
      res_we    <= (state_d == WRITE);
      res_sel   <= (state_d == WRITE) ? cnt_d : '0;
      res_addr  <= (state_d == WRITE) ? (base_d + AW'(cnt_d)) : '0;
    end
  end

endmodule
